powerup_receiver: RTL and testbench
===================================

// Module: powerup_receiver
// PURPOSE
//  Player-side consumer of the gift powerup interface. It captures a gift collection (player/gift collision)
//  and the gift type bit, then runs a frame-timed effect: shield or rapid fire. The effect raises a warning
//  and blinks before it expires. It sits beside the player block; its outputs gate player damage, set the
//  shot cooldown and drive player flashing.
// PARAMETERS
//  SHIELD_FRAMES      300  frames a shield (type 0) lasts
//  RAPID_FIRE_FRAMES  600  frames a rapid-fire (type 1) lasts
//  WARN_FRAMES        60   remaining-frame count at which EXPIRING starts (must be < both durations)
//  BLINK_PERIOD       8    frames per blink half-period while EXPIRING
//  FRAME_CNT_WIDTH    10   width of frames_left (must hold max duration)
// PORTS
//  clk                in   1   system clock
//  reset              in   1   synchronous, active-high reset
//  enable             in   1   game running; low freezes all timers and ignores collections
//  startOfFrame       in   1   one-cycle pulse per video frame
//  collected          in   1   player/gift collision qualified with gift drawing request; may be high many cycles per frame
//  powerup            in   1   gift type, valid while collected high: 1=rapid fire, 0=shield
//  collect_ack        out  1   one-cycle pulse on the accepted collection cycle
//  shield_active      out  1   shield effect running (ACTIVE or EXPIRING)
//  rapid_fire_active  out  1   rapid-fire effect running (ACTIVE or EXPIRING)
//  expiring           out  1   state==EXPIRING
//  blink              out  1   player visibility: 0 IDLE, 1 ACTIVE, toggling in EXPIRING
//  frames_left        out  FRAME_CNT_WIDTH  remaining frames of current effect, 0 when IDLE
// BEHAVIOUR
//  - Reset: state IDLE, pending=0, taken=0, all outputs 0, blink counter 0. Reset wins over all inputs.
//  - All outputs registered. Effect outputs change the cycle after the consuming startOfFrame.
//  - Capture: when enable=1 and collected=1 and taken=0, set pending=1, pending_type=powerup, taken=1, collect_ack=1.
//    Further collected cycles in the same frame are ignored; collect_ack does not repeat.
//  - taken clears on startOfFrame. A collection in the same cycle as startOfFrame belongs to the new frame:
//    it is captured (taken=1, pending=1) and applied at the NEXT startOfFrame.
//  - Frame step (startOfFrame & enable), priority order:
//    1) pending=1: load frames_left with the duration for pending_type, set active type, go ACTIVE, clear pending.
//       Same type refreshes to full duration (no accumulation). Other type replaces the current effect.
//    2) else ACTIVE/EXPIRING: frames_left-=1. New value == WARN_FRAMES -> EXPIRING, blink counter cleared, blink=0.
//       New value == 0 -> IDLE.
//    3) else IDLE: hold.
//  - States: IDLE -(pending@SOF)-> ACTIVE -(frames_left==WARN)-> EXPIRING -(frames_left==0)-> IDLE;
//    ACTIVE/EXPIRING -(pending@SOF)-> ACTIVE.
//  - EXPIRING blink: toggles each BLINK_PERIOD frames. The blink counter is clocked by the frame step.
//  - enable=0: no capture, no decrement, no state change; pending/taken hold; outputs hold.
//  - No wrap-around: frames_left never decrements below 0.
//  - shield_active = (state!=IDLE) & type==0; rapid_fire_active = (state!=IDLE) & type==1.
//  - Reset mid-effect: returns to IDLE the next cycle; any pending collection is discarded.
// STRUCTURE
//  - Shared package: typedef enum logic {POWERUP_SHIELD=1'b0, POWERUP_RAPID_FIRE=1'b1} powerup_t;
//    typedef enum logic [1:0] {PU_IDLE, PU_ACTIVE, PU_EXPIRING} powerup_state_t; default duration constants.
//  - One sub-module, frame_timer: loadable down-counter stepped on frame pulses. It has load/value/step inputs,
//    count output and zero/warn flags. Capture logic and FSM stay in powerup_receiver.
// TESTING (SHIELD_FRAMES=5, RAPID_FIRE_FRAMES=8, WARN_FRAMES=2, BLINK_PERIOD=1)
//  - Reset: hold reset 3 cycles with collected=1 -> all outputs 0, no collect_ack, state IDLE.
//  - Shield lifecycle: collected=1,powerup=0 for 20 cycles mid-frame -> exactly one collect_ack.
//    Next SOF -> shield_active=1, frames_left=5. SOF #4 -> expiring=1, frames_left=2.
//    SOF #5 -> frames_left=1, blink toggled. SOF #6 -> IDLE, frames_left=0.
//  - Replace/refresh: shield at frames_left=3, collect powerup=1 -> next SOF rapid_fire_active=1,
//    shield_active=0, frames_left=8. Collect powerup=1 again at 4 -> frames_left=8.
//  - Simultaneous: collected rises the same cycle as SOF -> collect_ack that cycle, no effect at that SOF,
//    effect loaded at the following SOF.
//  - Freeze: enable=0 for 3 SOFs while ACTIVE at frames_left=6 -> frames_left stays 6.
//    Collections ignored and no collect_ack.
//  - Reset mid-effect with pending set -> IDLE next cycle; following SOF loads nothing.

Source files
------------

// File: rtl/powerup_receiver_pkg.sv
// Shared types and default durations for the gift powerup receiver.
package powerup_receiver_pkg;

  typedef enum logic {
    POWERUP_SHIELD     = 1'b0,
    POWERUP_RAPID_FIRE = 1'b1
  } powerup_t;

  typedef enum logic [1:0] {
    PU_IDLE,
    PU_ACTIVE,
    PU_EXPIRING
  } powerup_state_t;

  localparam int DEFAULT_SHIELD_FRAMES     = 300;
  localparam int DEFAULT_RAPID_FIRE_FRAMES = 600;
  localparam int DEFAULT_WARN_FRAMES       = 60;
  localparam int DEFAULT_BLINK_PERIOD      = 8;
  localparam int DEFAULT_FRAME_CNT_WIDTH   = 10;

endpackage

// File: rtl/powerup_receiver_if.sv
// Gift collection handshake between the gift block (master) and the player-side receiver (slave).
interface powerup_receiver_if;

  logic collected;
  logic powerup;
  logic collect_ack;

  modport master (output collected, output powerup, input collect_ack);
  modport slave  (input collected, input powerup, output collect_ack);

endinterface

// File: rtl/powerup_receiver_frame_timer.sv
// Loadable down-counter stepped once per frame; stops at zero.
module frame_timer #(
  parameter int WIDTH      = 10,
  parameter int WARN_VALUE = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             step,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             warn
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (step && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // Flags look ahead: they tell the owner what the count becomes after the next step.
  assign zero = (count == WIDTH'(1));
  assign warn = (count == WIDTH'(WARN_VALUE + 1));

endmodule

// File: rtl/powerup_receiver.sv
// Player-side gift consumer: captures one collection per frame and runs a timed shield or rapid-fire effect.
module powerup_receiver
  import powerup_receiver_pkg::*;
#(
  parameter int SHIELD_FRAMES     = DEFAULT_SHIELD_FRAMES,
  parameter int RAPID_FIRE_FRAMES = DEFAULT_RAPID_FIRE_FRAMES,
  parameter int WARN_FRAMES       = DEFAULT_WARN_FRAMES,
  parameter int BLINK_PERIOD      = DEFAULT_BLINK_PERIOD,
  parameter int FRAME_CNT_WIDTH   = DEFAULT_FRAME_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       startOfFrame,
  powerup_receiver_if.slave          gift,
  output logic                       shield_active,
  output logic                       rapid_fire_active,
  output logic                       expiring,
  output logic                       blink,
  output logic [FRAME_CNT_WIDTH-1:0] frames_left
);

  localparam int BCW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  powerup_state_t state, stateNext;
  powerup_t       activeType, typeNext, pendingType, pendingTypeNext;
  logic           pending, pendingNext, taken, takenNext;
  logic           blinkNext, collectAck;
  logic [BCW-1:0] blinkCnt, blinkCntNext;

  logic                       frameStep, capture, timerLoad, timerStep;
  logic                       timerZero, timerWarn;
  logic [FRAME_CNT_WIDTH-1:0] loadValue;

  frame_timer #(
    .WIDTH      (FRAME_CNT_WIDTH),
    .WARN_VALUE (WARN_FRAMES)
  ) timer (
    .clk   (clk),
    .reset (reset),
    .load  (timerLoad),
    .value (loadValue),
    .step  (timerStep),
    .count (frames_left),
    .zero  (timerZero),
    .warn  (timerWarn)
  );

  always_comb begin
    frameStep = startOfFrame & enable;
    // A collection coinciding with the frame pulse belongs to the new frame, so the old taken flag is ignored.
    capture   = enable & gift.collected & ~(taken & ~frameStep);
    timerLoad = frameStep & pending;
    timerStep = frameStep & ~pending & (state != PU_IDLE);
    loadValue = (pendingType == POWERUP_RAPID_FIRE) ? FRAME_CNT_WIDTH'(RAPID_FIRE_FRAMES)
                                                    : FRAME_CNT_WIDTH'(SHIELD_FRAMES);

    stateNext       = state;
    typeNext        = activeType;
    blinkNext       = blink;
    blinkCntNext    = blinkCnt;
    pendingNext     = pending;
    pendingTypeNext = pendingType;
    takenNext       = taken;

    if (frameStep) takenNext   = 1'b0;
    if (timerLoad) pendingNext = 1'b0;
    if (capture) begin
      pendingNext     = 1'b1;
      pendingTypeNext = powerup_t'(gift.powerup);
      takenNext       = 1'b1;
    end

    if (timerLoad) begin
      stateNext    = PU_ACTIVE;
      typeNext     = pendingType;
      blinkNext    = 1'b1;
      blinkCntNext = '0;
    end else if (timerStep) begin
      if (timerZero) begin
        stateNext    = PU_IDLE;
        blinkNext    = 1'b0;
        blinkCntNext = '0;
      end else if (timerWarn) begin
        stateNext    = PU_EXPIRING;
        blinkNext    = 1'b0;
        blinkCntNext = '0;
      end else if (state == PU_EXPIRING) begin
        if (blinkCnt == BCW'(BLINK_PERIOD - 1)) begin
          blinkNext    = ~blink;
          blinkCntNext = '0;
        end else begin
          blinkCntNext = blinkCnt + BCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= PU_IDLE;
      activeType        <= POWERUP_SHIELD;
      pendingType       <= POWERUP_SHIELD;
      pending           <= 1'b0;
      taken             <= 1'b0;
      blinkCnt          <= '0;
      blink             <= 1'b0;
      collectAck        <= 1'b0;
      shield_active     <= 1'b0;
      rapid_fire_active <= 1'b0;
      expiring          <= 1'b0;
    end else begin
      state             <= stateNext;
      activeType        <= typeNext;
      pendingType       <= pendingTypeNext;
      pending           <= pendingNext;
      taken             <= takenNext;
      blinkCnt          <= blinkCntNext;
      blink             <= blinkNext;
      collectAck        <= capture;
      shield_active     <= (stateNext != PU_IDLE) && (typeNext == POWERUP_SHIELD);
      rapid_fire_active <= (stateNext != PU_IDLE) && (typeNext == POWERUP_RAPID_FIRE);
      expiring          <= (stateNext == PU_EXPIRING);
    end
  end

  assign gift.collect_ack = collectAck;

endmodule

// File: tb/tb_powerup_receiver.sv
// Directed scoreboard bench for powerup_receiver with short durations so full effect lifecycles fit.
module tb_powerup_receiver;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       startOfFrame;
  logic       shieldActive;
  logic       rapidFireActive;
  logic       expiringOut;
  logic       blinkOut;
  logic [9:0] framesLeft;

  int vectors   = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [4:0] flags;
    logic [9:0] frames;
  } expect_t;

  expect_t sbQ[$];

  powerup_receiver_if gift();

  powerup_receiver #(
    .SHIELD_FRAMES     (5),
    .RAPID_FIRE_FRAMES (8),
    .WARN_FRAMES       (2),
    .BLINK_PERIOD      (1),
    .FRAME_CNT_WIDTH   (10)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .startOfFrame      (startOfFrame),
    .gift              (gift.slave),
    .shield_active     (shieldActive),
    .rapid_fire_active (rapidFireActive),
    .expiring          (expiringOut),
    .blink             (blinkOut),
    .frames_left       (framesLeft)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags are packed as {collect_ack, shield_active, rapid_fire_active, expiring, blink}.
  task automatic checkOutput();
    expect_t    x;
    logic [4:0] obsFlags;
    vectors++;
    if (sbQ.size() == 0) begin
      miscompares++;
      $error("[TB] FAIL scoreboard_empty observed=0 entries expected=1 entry");
      return;
    end
    x = sbQ.pop_front();
    obsFlags = {gift.collect_ack, shieldActive, rapidFireActive, expiringOut, blinkOut};
    assert (obsFlags === x.flags) else begin
      miscompares++;
      $error("[TB] FAIL %s flags observed=%b expected=%b", x.tag, obsFlags, x.flags);
    end
    vectors++;
    assert (framesLeft === x.frames) else begin
      miscompares++;
      $error("[TB] FAIL %s frames_left observed=%0d expected=%0d", x.tag, framesLeft, x.frames);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic sof, input logic col,
                               input logic pu, input string tag, input logic [4:0] f, input int fl);
    expect_t x;
    reset          = r;
    enable         = en;
    startOfFrame   = sof;
    gift.collected = col;
    gift.powerup   = pu;
    x.tag    = tag;
    x.flags  = f;
    x.frames = 10'(fl);
    sbQ.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  // One frame: the pulse cycle followed by two quiet cycles that must hold the same effect outputs.
  task automatic frame(input string tag, input logic en, input logic col, input logic pu,
                       input logic [4:0] f, input int fl);
    applyStimulus(1'b0, en, 1'b1, col, pu, tag, f, fl);
    applyStimulus(1'b0, en, 1'b0, col, pu, {tag, "_hold"}, f & 5'b01111, fl);
    applyStimulus(1'b0, en, 1'b0, col, pu, {tag, "_hold"}, f & 5'b01111, fl);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; startOfFrame = 1'b0;
    gift.collected = 1'b0; gift.powerup = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "reset0", 5'b00000, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "reset1", 5'b00000, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "reset2", 5'b00000, 0);

    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, (i == 0) ? "shield_ack" : "shield_noack",
                    (i == 0) ? 5'b10000 : 5'b00000, 0);

    frame("shield_sof1", 1'b1, 1'b0, 1'b0, 5'b01001, 5);
    frame("shield_sof2", 1'b1, 1'b0, 1'b0, 5'b01001, 4);
    frame("shield_sof3", 1'b1, 1'b0, 1'b0, 5'b01001, 3);
    frame("shield_sof4", 1'b1, 1'b0, 1'b0, 5'b01010, 2);
    frame("shield_sof5", 1'b1, 1'b0, 1'b0, 5'b01011, 1);
    frame("shield_sof6", 1'b1, 1'b0, 1'b0, 5'b00000, 0);
    frame("idle_nowrap", 1'b1, 1'b0, 1'b0, 5'b00000, 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "repl_shield_ack", 5'b10000, 0);
    frame("repl_sof1", 1'b1, 1'b0, 1'b0, 5'b01001, 5);
    frame("repl_sof2", 1'b1, 1'b0, 1'b0, 5'b01001, 4);
    frame("repl_sof3", 1'b1, 1'b0, 1'b0, 5'b01001, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "repl_rapid_ack", 5'b11001, 3);
    frame("repl_rapid_load", 1'b1, 1'b0, 1'b0, 5'b00101, 8);
    frame("rapid_7", 1'b1, 1'b0, 1'b0, 5'b00101, 7);
    frame("rapid_6", 1'b1, 1'b0, 1'b0, 5'b00101, 6);
    frame("rapid_5", 1'b1, 1'b0, 1'b0, 5'b00101, 5);
    frame("rapid_4", 1'b1, 1'b0, 1'b0, 5'b00101, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "refresh_ack", 5'b10101, 4);
    frame("refresh_load", 1'b1, 1'b0, 1'b0, 5'b00101, 8);
    frame("rapid_7b", 1'b1, 1'b0, 1'b0, 5'b00101, 7);
    frame("rapid_6b", 1'b1, 1'b0, 1'b0, 5'b00101, 6);

    frame("freeze1", 1'b0, 1'b1, 1'b0, 5'b00101, 6);
    frame("freeze2", 1'b0, 1'b1, 1'b0, 5'b00101, 6);
    frame("freeze3", 1'b0, 1'b1, 1'b0, 5'b00101, 6);
    frame("unfreeze", 1'b1, 1'b0, 1'b0, 5'b00101, 5);

    frame("simul_sof", 1'b1, 1'b1, 1'b0, 5'b10101, 4);
    frame("simul_load", 1'b1, 1'b0, 1'b0, 5'b01001, 5);

    frame("rst_mid_sof", 1'b1, 1'b0, 1'b0, 5'b01001, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "rst_mid_ack", 5'b11001, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_mid", 5'b00000, 0);
    frame("rst_mid_noload", 1'b1, 1'b0, 1'b0, 5'b00000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
